// File: rtl/apb_pkg.sv
// Shared APB types: bus address/data widths, requester FSM states and the
// latched command record.
package apb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

  typedef struct packed {
    logic  write;
    addr_t addr;
    data_t wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle; the requester uses the master modport and the completer
// uses the slave modport.
interface apb_if;
  import apb_pkg::*;

  logic  PSEL;
  logic  PENABLE;
  logic  PWRITE;
  addr_t PADDR;
  data_t PWDATA;
  logic  PREADY;
  logic  PSLVERR;
  data_t PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PSLVERR, PRDATA
  );

endinterface

// File: rtl/apb_mst_timer.sv
// ACCESS-phase wait counter for the APB requester; expired flags the wait
// cycle that would bring the count up to TIMEOUT_CYCLES.
module apb_mst_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command stream into single APB transfers
// and returns one response per command. Optional ACCESS timeout: APB_MST_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic   PCLK,
  input  logic   PRESETn,
  input  logic   cmd_valid,
  output logic   cmd_ready,
  input  logic   cmd_write,
  input  addr_t  cmd_addr,
  input  data_t  cmd_wdata,
  output logic   rsp_valid,
  input  logic   rsp_ready,
  output data_t  rsp_rdata,
  output logic   rsp_err,
  output logic   rsp_timeout,
  apb_if.master  apb
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be >= 1");
  end

  apb_mst_state_e state;
  apb_cmd_t       cmd;
  logic           timeout_hit;

  assign cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

`ifdef APB_MST_TIMEOUT_EN
  apb_mst_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clear   (state == SETUP),
    .enable  ((state == ACCESS) && !apb.PREADY),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // PADDR/PWRITE/PWDATA keep their last value after a transfer; only reset clears them.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the pre-edge state.
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            apb.PADDR  <= cmd.addr;
            apb.PWRITE <= cmd.write;
            apb.PWDATA <= cmd.wdata;
            apb.PSEL   <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          apb.PENABLE <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          // PREADY on the final counted cycle still completes normally.
          if (apb.PREADY) begin
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= apb.PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= apb.PWRITE ? '0 : apb.PRDATA;
            state       <= RESP;
          end else if (timeout_hit) begin
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized
// traffic against a transaction-level memory model of the APB completer.
module tb_apb_master;
  import apb_pkg::*;

  localparam int unsigned TO = 4;

  logic  PCLK = 1'b0;
  logic  PRESETn = 1'b0;
  logic  cmd_valid = 1'b0;
  logic  cmd_ready;
  logic  cmd_write = 1'b0;
  addr_t cmd_addr = '0;
  data_t cmd_wdata = '0;
  logic  rsp_valid;
  logic  rsp_ready = 1'b0;
  data_t rsp_rdata;
  logic  rsp_err;
  logic  rsp_timeout;

  apb_if bus();

  apb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb         (bus)
  );

  always #5 PCLK = ~PCLK;

  int unsigned cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Completer memory as seen at transaction level; unwritten words read as ~addr.
  data_t mem [addr_t];

  function automatic data_t mem_rd(input addr_t a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  task automatic junk_completer();
    bus.PREADY  = 1'($urandom_range(0, 1));
    bus.PSLVERR = 1'($urandom_range(0, 1));
    bus.PRDATA  = $urandom;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge PCLK);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b after 20 cycles, required 1", cmd_ready);
    end
  endtask

  // One complete transfer with per-cycle expectations derived from the protocol
  // timing: SETUP one cycle after accept, ACCESS for waits+1 cycles, then RESP.
  task automatic xfer(input bit wr, input addr_t a, input data_t wd, input int waits,
                      input bit err, input int hold, input bit keep_valid);
    bit    ok;
    data_t exp_rdata;
    wait_ready(ok);
    if (!ok) return;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    @(negedge PCLK);
    // Scramble the command side: the DUT must have latched the transfer already.
    cmd_valid = keep_valid;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    checks++;
    if ({bus.PSEL, bus.PENABLE, cmd_ready, rsp_valid} !== 4'b1000 || bus.PADDR !== a ||
        bus.PWRITE !== wr || (wr && bus.PWDATA !== wd)) begin
      errors++;
      $display("FAIL setup: sel/en/rdy/rv=%b%b%b%b addr=%h wr=%b wdata=%h, required 1000 addr=%h wr=%b wdata=%h",
               bus.PSEL, bus.PENABLE, cmd_ready, rsp_valid, bus.PADDR, bus.PWRITE, bus.PWDATA, a, wr, wd);
    end
    junk_completer();
    @(negedge PCLK);
    exp_rdata = wr ? '0 : mem_rd(a);
    for (int w = 0; w <= waits; w++) begin
      checks++;
      if ({bus.PSEL, bus.PENABLE, cmd_ready, rsp_valid} !== 4'b1100 || bus.PADDR !== a ||
          bus.PWRITE !== wr || (wr && bus.PWDATA !== wd)) begin
        errors++;
        $display("FAIL access[%0d]: sel/en/rdy/rv=%b%b%b%b addr=%h wr=%b, required 1100 addr=%h wr=%b",
                 w, bus.PSEL, bus.PENABLE, cmd_ready, rsp_valid, bus.PADDR, bus.PWRITE, a, wr);
      end
      if (w < waits) begin
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'($urandom_range(0, 1));
        bus.PRDATA  = $urandom;
      end else begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = err;
        bus.PRDATA  = wr ? $urandom : mem_rd(a);
      end
      @(negedge PCLK);
    end
    if (wr) mem[a] = wd;
    junk_completer();
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold);
      if (h == hold) cmd_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || cmd_ready !== 1'b0 ||
          rsp_rdata !== exp_rdata || rsp_err !== err || rsp_timeout !== 1'b0 || bus.PADDR !== a) begin
        errors++;
        $display("FAIL resp[%0d]: rv=%b sel=%b en=%b rdy=%b rdata=%h err=%b to=%b addr=%h, required 1 0 0 0 %h %b 0 %h",
                 h, rsp_valid, bus.PSEL, bus.PENABLE, cmd_ready, rsp_rdata, rsp_err, rsp_timeout,
                 bus.PADDR, exp_rdata, err, a);
      end
      @(negedge PCLK);
    end
    rsp_ready = 1'($urandom_range(0, 1));
    checks++;
    if ({rsp_valid, cmd_ready, bus.PSEL} !== 3'b010) begin
      errors++;
      $display("FAIL consume: rv/rdy/sel=%b%b%b, required 010", rsp_valid, cmd_ready, bus.PSEL);
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    junk_completer();
    repeat (3) @(negedge PCLK);
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, cmd_ready, rsp_valid, rsp_err, rsp_timeout} !== 7'b0 ||
        bus.PADDR !== '0 || bus.PWDATA !== '0 || rsp_rdata !== '0) begin
      errors++;
      $display("FAIL reset_state: sel/en/wr/rdy/rv/err/to=%b%b%b%b%b%b%b addr=%h wdata=%h rdata=%h, required all 0",
               bus.PSEL, bus.PENABLE, bus.PWRITE, cmd_ready, rsp_valid, rsp_err, rsp_timeout,
               bus.PADDR, bus.PWDATA, rsp_rdata);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
  endtask

  task automatic test_write_zero_wait();
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_read_wait();
    xfer(1'b0, 32'h10, 32'h0, 3, 1'b0, 0, 1'b0);
  endtask

  task automatic test_slverr();
    xfer(1'b0, 32'hFFC, 32'h0, 0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_rsp_backpressure();
    xfer(1'b1, 32'h24, 32'h1234_5678, 1, 1'b0, 5, 1'b1);
  endtask

  task automatic test_back_to_back();
    int unsigned c0;
    int unsigned span;
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      xfer(i[0], 32'h30 + 32'(i * 4), $urandom, 0, 1'b0, 0, 1'b0);
    end
    span = cyc - c0;
    checks++;
    if (span !== 16) begin
      errors++;
      $display("FAIL back_to_back: %0d cycles for 4 transfers, required 16", span);
    end
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    bit seen;
    wait_ready(ok);
    if (!ok) return;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h40;
    cmd_wdata = 32'hCAFE_F00D;
    @(negedge PCLK);
    cmd_valid  = 1'b0;
    bus.PREADY = 1'b0;
    @(negedge PCLK);
    #1 PRESETn = 1'b0;
    #1;
    checks++;
    if ({bus.PSEL, bus.PENABLE, cmd_ready, rsp_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: sel/en/rdy/rv=%b%b%b%b, required 0000",
               bus.PSEL, bus.PENABLE, cmd_ready, rsp_valid);
    end
    @(negedge PCLK);
    PRESETn    = 1'b1;
    bus.PREADY = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_rsp: rsp_valid or PSEL rose after reset release, required both 0");
    end
    bus.PREADY = 1'b0;
  endtask

`ifdef APB_MST_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h20;
    @(negedge PCLK);
    cmd_valid  = 1'b0;
    bus.PREADY = 1'b0;
    @(negedge PCLK);
    for (int i = 0; i < int'(TO); i++) begin
      checks++;
      if ({bus.PSEL, bus.PENABLE, rsp_valid} !== 3'b110) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: sel/en/rv=%b%b%b, required 110", i, bus.PSEL, bus.PENABLE, rsp_valid);
      end
      bus.PSLVERR = 1'($urandom_range(0, 1));
      @(negedge PCLK);
    end
    checks++;
    if ({bus.PSEL, bus.PENABLE, rsp_valid, rsp_err, rsp_timeout} !== 5'b00111 || rsp_rdata !== '0) begin
      errors++;
      $display("FAIL timeout_rsp: sel/en/rv/err/to=%b%b%b%b%b rdata=%h, required 00111 0",
               bus.PSEL, bus.PENABLE, rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_consume: rv/rdy=%b%b, required 01", rsp_valid, cmd_ready);
    end
    // PREADY on the last countable cycle completes normally.
    xfer(1'b0, 32'h10, 32'h0, int'(TO) - 1, 1'b0, 0, 1'b0);
  endtask
`else
  task automatic test_long_wait();
    xfer(1'b0, 32'h14, 32'h0, 20, 1'b0, 0, 1'b0);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      xfer(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 7) * 4), $urandom,
           $urandom_range(0, int'(TO) - 1), ($urandom_range(0, 7) == 0), $urandom_range(0, 2),
           1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = '0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_rsp_backpressure();
    test_back_to_back();
`ifdef APB_MST_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
